ddr3_axi_memtest: RTL and testbench

Parametrised AXI4 master traffic generator and checker that drives the ddr3_axi slave port in place of the user design. On each start it fills a configurable address window using burst writes, then reads the window back and compares every beat against a regenerated pattern. It reports pass/fail, a saturating error count and the address of the first failing beat. It is the generalised successor to the fixed, hand-wired board test: data width, burst length, window and pattern mode are all configurable.

---
 rtl/ddr3_axi_memtest_if.sv | 70 +++++++
 rtl/ddr3_axi_memtest.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ddr3_axi_memtest.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_axi_memtest_if.sv
// AXI4 bus between the memory test master and the ddr3_axi slave port.
// Carries the five AXI4 channels. The master modport is used by the traffic
// generator and the slave modport by the memory or a behavioural model.
interface ddr3_axi_memtest_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) ();
    // Write address channel
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           awaddr;
    logic [ID_W-1:0]       awid;
    logic [7:0]            awlen;
    logic [1:0]            awburst;

    // Write data channel
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    // Write response channel
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [ID_W-1:0]       bid;

    // Read address channel
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           araddr;
    logic [ID_W-1:0]       arid;
    logic [7:0]            arlen;
    logic [1:0]            arburst;

    // Read data channel
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic [ID_W-1:0]       rid;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );
endinterface

// File: rtl/ddr3_axi_memtest.sv
// AXI4 memory test master.
// Fills an address window using INCR burst writes. It then reads the window
// back and checks every beat against a regenerated pattern. The result is a
// pass flag, a saturating error count and the address of the first failing
// beat. Only one transaction is outstanding at a time.
module ddr3_axi_memtest #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ID_W         = 4,
    parameter int unsigned BURST_LEN    = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] WINDOW_BYTES = 32'h10000,
    parameter int unsigned AXI_ID       = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [31:0]        seed_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [31:0]        err_count_o,
    output logic [31:0]        err_addr_o,
    ddr3_axi_memtest_if.master outport
);

    localparam int unsigned LANES       = DATA_W / 32;
    localparam logic [31:0] BEAT_BYTES  = 32'(DATA_W / 8);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN) * BEAT_BYTES;
    localparam logic [31:0] END_ADDR    = BASE_ADDR + WINDOW_BYTES;
    localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [4:0]  BURST_MOD32 = 5'(BURST_LEN);
    localparam logic [ID_W-1:0] ID_VAL  = ID_W'(AXI_ID);
    localparam logic [31:0] LFSR_POLY   = 32'h80200003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] addr_q, addr_d;          // byte address of the current burst
    logic [8:0]  beat_q, beat_d;          // beat index inside the current burst
    logic [4:0]  wburst_q, wburst_d;      // window beat index of burst start, mod 32
    logic [31:0] err_count_q, err_count_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0]       lfsr_step;
    logic [31:0]       beat_addr;
    logic [31:0]       next_addr;
    logic              window_end;
    logic [4:0]        widx;
    logic [31:0]       pat_word;
    logic [DATA_W-1:0] pattern;
    logic [1:0]        err_inc;
    logic [31:0]       err_at;
    logic [32:0]       err_sum;
    logic              data_bad;
    logic              rlast_bad;
    logic              beat_is_last;

    // Galois LFSR advance and address bookkeeping shared by both phases
    always_comb begin
        lfsr_step    = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
        beat_addr    = addr_q + (32'(beat_q) * BEAT_BYTES);
        next_addr    = addr_q + BURST_BYTES;
        window_end   = (next_addr == END_ADDR);
        widx         = wburst_q + beat_q[4:0];
        beat_is_last = (beat_q == LAST_BEAT);
    end

    // Base 32-bit pattern word for the current beat, selected by the latched mode
    always_comb begin
        pat_word = beat_addr;
        case (mode_q)
            2'd0:    pat_word = beat_addr;
            2'd1:    pat_word = lfsr_q;
            2'd2:    pat_word = 32'h1 << widx;
            default: pat_word = ~beat_addr;
        endcase
    end

    // Each 32-bit lane carries the base word XORed with its lane number
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign pattern[gi*32 +: 32] = pat_word ^ 32'(gi);
    end

    // Next-state and datapath update for the test sequencer
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        lfsr_d      = lfsr_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        wburst_d    = wburst_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        err_inc     = 2'd0;
        err_at      = beat_addr;
        data_bad    = 1'b0;
        rlast_bad   = 1'b0;
        err_sum     = 33'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    // An all-zero seed would lock the LFSR at zero
                    seed_d      = (seed_i == 32'h0) ? 32'h1 : seed_i;
                    lfsr_d      = (seed_i == 32'h0) ? 32'h1 : seed_i;
                    err_count_d = 32'h0;
                    err_addr_d  = 32'h0;
                    addr_d      = BASE_ADDR;
                    beat_d      = 9'd0;
                    wburst_d    = 5'd0;
                    state_d     = S_AW;
                end
            end

            S_AW: begin
                if (outport.awready) begin
                    state_d = S_W;
                end
            end

            S_W: begin
                if (outport.wready) begin
                    lfsr_d = lfsr_step;
                    if (beat_is_last) begin
                        beat_d  = 9'd0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end

            S_B: begin
                if (outport.bvalid) begin
                    if ((outport.bresp != 2'b00) || (outport.bid != ID_VAL)) begin
                        err_inc = 2'd1;
                    end
                    err_at   = addr_q;
                    wburst_d = wburst_q + BURST_MOD32;
                    if (window_end) begin
                        // Read phase replays the pattern from the start of the window
                        addr_d   = BASE_ADDR;
                        lfsr_d   = seed_q;
                        wburst_d = 5'd0;
                        state_d  = S_AR;
                    end else begin
                        addr_d  = next_addr;
                        state_d = S_AW;
                    end
                end
            end

            S_AR: begin
                if (outport.arready) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (outport.rvalid) begin
                    lfsr_d    = lfsr_step;
                    data_bad  = (outport.rdata != pattern) || (outport.rresp != 2'b00);
                    rlast_bad = beat_is_last ? !outport.rlast : outport.rlast;
                    err_inc   = {1'b0, data_bad} + {1'b0, rlast_bad};
                    // An early rlast ends the burst at once. In LFSR mode the
                    // remaining bursts then compare against a shifted sequence.
                    if (beat_is_last || outport.rlast) begin
                        beat_d   = 9'd0;
                        wburst_d = wburst_q + BURST_MOD32;
                        if (window_end) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = next_addr;
                            state_d = S_AR;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturating error accumulation; the first error pins its address
        if (err_inc != 2'd0) begin
            err_sum     = {1'b0, err_count_q} + {31'b0, err_inc};
            err_count_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            if (err_count_q == 32'h0) begin
                err_addr_d = err_at;
            end
        end
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            seed_q      <= 32'h0;
            lfsr_q      <= 32'h0;
            addr_q      <= 32'h0;
            beat_q      <= 9'd0;
            wburst_q    <= 5'd0;
            err_count_q <= 32'h0;
            err_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            lfsr_q      <= lfsr_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            wburst_q    <= wburst_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // AXI outputs decoded from the state; valids stay high until the handshake
    assign outport.awvalid = (state_q == S_AW);
    assign outport.awaddr  = addr_q;
    assign outport.awid    = ID_VAL;
    assign outport.awlen   = 8'(BURST_LEN - 1);
    assign outport.awburst = 2'b01;

    assign outport.wvalid  = (state_q == S_W);
    assign outport.wdata   = pattern;
    assign outport.wstrb   = '1;
    assign outport.wlast   = (state_q == S_W) && beat_is_last;

    assign outport.bready  = (state_q == S_B);

    assign outport.arvalid = (state_q == S_AR);
    assign outport.araddr  = addr_q;
    assign outport.arid    = ID_VAL;
    assign outport.arlen   = 8'(BURST_LEN - 1);
    assign outport.arburst = 2'b01;

    assign outport.rready  = (state_q == S_R);

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = (state_q == S_DONE) && (err_count_q == 32'h0);
    assign err_count_o = err_count_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_ddr3_axi_memtest.sv
// Testbench for ddr3_axi_memtest.
// A behavioural AXI slave with memory, stalls and fault injection sits on the
// bus. Expected AW addresses, W data and AR addresses go into queues when each
// test starts, and the slave pops and compares them as the DUT issues them.
module tb_ddr3_axi_memtest;

    localparam int          DW   = 32;
    localparam int          IDW  = 4;
    localparam int          BL   = 4;
    localparam int          NBUR = 4;
    localparam logic [31:0] WIN  = 32'd64;
    localparam logic [31:0] POLY = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = 32'h0;
    logic        busy, done, pass;
    logic [31:0] err_count, err_addr;

    ddr3_axi_memtest_if #(.DATA_W(DW), .ID_W(IDW)) axi ();

    ddr3_axi_memtest #(
        .DATA_W(DW), .ID_W(IDW), .BURST_LEN(BL),
        .BASE_ADDR(32'h0), .WINDOW_BYTES(WIN), .AXI_ID(0)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode), .seed_i(seed),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_count_o(err_count), .err_addr_o(err_addr),
        .outport(axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [31:0] first_wdata;
    int          w_seen;

    task automatic pop_check(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_extra: got 0x%08h required nothing", name, act);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        logic [31:0] s;
        s = x >> 1;
        if (x[0]) s = s ^ POLY;
        return s;
    endfunction

    task automatic gen_expected(input logic [1:0] m, input logic [31:0] sd);
        logic [31:0] lf;
        logic [31:0] a;
        logic [31:0] p;
        int          idx;
        exp_aw.delete();
        exp_w.delete();
        exp_ar.delete();
        lf  = (sd == 32'h0) ? 32'h1 : sd;
        idx = 0;
        for (int b = 0; b < NBUR; b++) begin
            exp_aw.push_back(32'(b * BL * 4));
            for (int k = 0; k < BL; k++) begin
                a = 32'(b * BL * 4 + k * 4);
                case (m)
                    2'd0:    p = a;
                    2'd1:    p = lf;
                    2'd2:    p = 32'h1 << (idx % 32);
                    default: p = ~a;
                endcase
                exp_w.push_back(p);
                lf = lfsr_next(lf);
                idx++;
            end
        end
        for (int b = 0; b < NBUR; b++) exp_ar.push_back(32'(b * BL * 4));
    endtask

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    bit          cfg_stall;
    logic [1:0]  cfg_bresp;
    bit          cfg_cor_en;
    logic [31:0] cfg_cor_addr;
    int          cfg_early;
    int          cfg_miss;

    logic [31:0] wr_addr, rd_addr;
    int          wbeat, rbeat, rd_burst;
    bit          w_open, b_pend, r_act;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    bit          aw_wait, w_wait, ar_wait;
    logic [31:0] aw_hold, w_hold, ar_hold;

    function automatic int stall_len();
        return cfg_stall ? int'($urandom_range(0, 5)) : 0;
    endfunction

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rid = '0; axi.rlast = 1'b0;
        w_open = 0; b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
    endtask

    // Observe the handshakes that the coming rising edge will complete
    task automatic slave_sample();
        if (aw_wait) begin
            check("aw_valid_held", 32'(axi.awvalid), 32'd1);
            check("aw_addr_held", axi.awaddr, aw_hold);
        end
        if (w_wait) begin
            check("w_valid_held", 32'(axi.wvalid), 32'd1);
            check("w_data_held", axi.wdata, w_hold);
        end
        if (ar_wait) begin
            check("ar_valid_held", 32'(axi.arvalid), 32'd1);
            check("ar_addr_held", axi.araddr, ar_hold);
        end
        aw_wait = axi.awvalid && !axi.awready; aw_hold = axi.awaddr;
        w_wait  = axi.wvalid && !axi.wready;   w_hold  = axi.wdata;
        ar_wait = axi.arvalid && !axi.arready; ar_hold = axi.araddr;

        if (axi.wvalid) check("w_after_aw", 32'(w_open), 32'd1);

        if (axi.awvalid && axi.awready) begin
            pop_check("aw_addr", axi.awaddr, exp_aw);
            check("aw_len", 32'(axi.awlen), 32'(BL - 1));
            check("aw_burst", 32'(axi.awburst), 32'd1);
            check("aw_id", 32'(axi.awid), 32'd0);
            wr_addr = axi.awaddr; wbeat = 0; w_open = 1;
            aw_cnt = stall_len();
        end
        if (axi.wvalid && axi.wready) begin
            check("w_strb", 32'(axi.wstrb), 32'hF);
            check("w_last", 32'(axi.wlast), 32'(wbeat == BL - 1));
            pop_check("w_data", axi.wdata, exp_w);
            if (w_seen == 0) first_wdata = axi.wdata;
            w_seen++;
            mem[((wr_addr >> 2) + 32'(wbeat)) & 32'hF] = axi.wdata;
            wbeat++;
            if (wbeat == BL) begin w_open = 0; b_pend = 1; end
            w_cnt = stall_len();
        end
        if (axi.bvalid && axi.bready) b_pend = 0;
        if (axi.arvalid && axi.arready) begin
            pop_check("ar_addr", axi.araddr, exp_ar);
            check("ar_len", 32'(axi.arlen), 32'(BL - 1));
            check("ar_burst", 32'(axi.arburst), 32'd1);
            rd_addr = axi.araddr; rbeat = 0; r_act = 1;
            ar_cnt = stall_len();
        end
        if (axi.rvalid && axi.rready) begin
            rbeat++;
            if (axi.rlast || rbeat == BL) begin r_act = 0; rd_burst++; end
            r_cnt = stall_len();
        end
    endtask

    // Drive slave outputs for the next cycle, shortly after the rising edge
    task automatic slave_drive();
        logic [31:0] a;
        logic [31:0] d;
        if (aw_cnt > 0) begin axi.awready = 1'b0; aw_cnt--; end else axi.awready = 1'b1;
        if (w_cnt > 0)  begin axi.wready = 1'b0;  w_cnt--;  end else axi.wready = 1'b1;
        if (ar_cnt > 0) begin axi.arready = 1'b0; ar_cnt--; end else axi.arready = 1'b1;
        axi.bvalid = b_pend;
        axi.bresp  = b_pend ? cfg_bresp : 2'b00;
        axi.bid    = '0;
        if (r_act && r_cnt == 0) begin
            a = rd_addr + 32'(rbeat * 4);
            d = mem[(a >> 2) & 32'hF];
            if (cfg_cor_en && a == cfg_cor_addr) d = d ^ 32'h0000_0100;
            axi.rvalid = 1'b1;
            axi.rdata  = d;
            axi.rresp  = 2'b00;
            axi.rlast  = ((rbeat == BL - 1) && (rd_burst != cfg_miss)) ||
                         ((rd_burst == cfg_early) && (rbeat == 1));
        end else begin
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            if (r_cnt > 0) r_cnt--;
        end
    endtask

    initial begin
        slave_idle();
        forever begin
            @(negedge clk);
            if (rst_n) slave_sample();
            @(posedge clk);
            #1;
            if (!rst_n) slave_idle(); else slave_drive();
        end
    end

    // ---------------- test vectors ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        bit          stall;
        logic [1:0]  bresp;
        bit          cor_en;
        logic [31:0] cor_addr;
        int          early;
        int          miss;
        bit          mid_start;
        bit          chk_first;
        logic [31:0] exp_err;
        bit          exp_pass;
        logic [31:0] exp_eaddr;
    } tv_t;

    tv_t tv [10];

    task automatic run_vector(input tv_t t, input int num);
        int cyc;
        cfg_stall = t.stall; cfg_bresp = t.bresp; cfg_cor_en = t.cor_en;
        cfg_cor_addr = t.cor_addr; cfg_early = t.early; cfg_miss = t.miss;
        rd_burst = 0; w_seen = 0; first_wdata = 32'h0;
        gen_expected(t.mode, t.seed);
        @(negedge clk);
        mode = t.mode; seed = t.seed; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        if (t.mid_start) begin
            repeat (15) @(negedge clk);
            mode = t.mode ^ 2'b11; seed = 32'h1234_5678; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("pass", 32'(pass), 32'(t.exp_pass));
        check("err_count", err_count, t.exp_err);
        check("err_addr", err_addr, t.exp_eaddr);
        check("aw_left", 32'(exp_aw.size()), 32'd0);
        check("w_left", 32'(exp_w.size()), 32'd0);
        check("ar_left", 32'(exp_ar.size()), 32'd0);
        if (t.chk_first) check("first_wdata", first_wdata, 32'h1);
        $display("vector %0d: mode %0d seed 0x%08h err_count %0d err_addr 0x%08h pass %0d cycles %0d",
                 num, t.mode, t.seed, err_count, err_addr, pass, cyc);
    endtask

    initial begin
        int cyc;
        //         mode  seed           stl bresp  cor  cor_addr early miss mid first err  pass eaddr
        tv[0] = '{2'd0, 32'h0,        0, 2'b00, 0, 32'h00, -1, -1, 0, 0, 32'd0, 1, 32'h00};
        tv[1] = '{2'd0, 32'h0,        0, 2'b00, 1, 32'h24, -1, -1, 0, 0, 32'd1, 0, 32'h24};
        tv[2] = '{2'd1, 32'h0,        0, 2'b00, 0, 32'h00, -1, -1, 0, 1, 32'd0, 1, 32'h00};
        tv[3] = '{2'd1, 32'hDEADBEEF, 1, 2'b00, 0, 32'h00, -1, -1, 0, 0, 32'd0, 1, 32'h00};
        tv[4] = '{2'd2, 32'h0,        1, 2'b00, 0, 32'h00, -1, -1, 0, 0, 32'd0, 1, 32'h00};
        tv[5] = '{2'd3, 32'h0,        1, 2'b00, 0, 32'h00, -1, -1, 1, 0, 32'd0, 1, 32'h00};
        tv[6] = '{2'd0, 32'h0,        0, 2'b10, 0, 32'h00,  2, -1, 0, 0, 32'd5, 0, 32'h00};
        tv[7] = '{2'd0, 32'h0,        0, 2'b00, 0, 32'h00, -1,  1, 0, 0, 32'd1, 0, 32'h1C};
        tv[8] = '{2'd2, 32'h0,        0, 2'b00, 1, 32'h08, -1, -1, 0, 0, 32'd1, 0, 32'h08};
        tv[9] = '{2'd1, 32'h5,        1, 2'b00, 1, 32'h3C, -1, -1, 0, 0, 32'd1, 0, 32'h3C};

        cfg_stall = 0; cfg_bresp = 2'b00; cfg_cor_en = 0; cfg_cor_addr = 32'h0;
        cfg_early = -1; cfg_miss = -1; rd_burst = 0; w_seen = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err_count", err_count, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vector(tv[i], i);

        // Reset in the middle of the write data phase
        cfg_stall = 1; cfg_bresp = 2'b00; cfg_cor_en = 0; cfg_early = -1; cfg_miss = -1;
        rd_burst = 0; w_seen = 0;
        gen_expected(2'd0, 32'h0);
        @(negedge clk);
        mode = 2'd0; seed = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(axi.wvalid && w_seen > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_mid_w", 32'(axi.wvalid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("midrst_valids_next", 32'({axi.awvalid, axi.wvalid, axi.arvalid}), 32'd0);
        check("midrst_err_count", err_count, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        $display("mid-write reset applied and released");
        run_vector(tv[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Last-resort guard in case a bounded wait is somehow bypassed
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
